// File: rtl/int_sram_resp.sv
// int_sram_resp: single-port SRAM responder arbitrating a boot-loader write port over a
// CPU port, with one-cycle CPU completion and a saturating boot-write counter.
module int_sram_resp #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int SRAM_ADDR_W = 13
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     boot_valid,
  input  logic [ADDR_W-1:0]        boot_addr,
  input  logic [DATA_W-1:0]        boot_wdata,
  input  logic [DATA_W/8-1:0]      boot_wstrb,
  input  logic                     cpu_valid,
  input  logic [SRAM_ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]        cpu_wdata,
  input  logic [DATA_W/8-1:0]      cpu_wstrb,
  output logic [DATA_W-1:0]        cpu_rdata,
  output logic                     cpu_ready,
  output logic                     mem_en,
  output logic [DATA_W/8-1:0]      mem_we,
  output logic [SRAM_ADDR_W-3:0]   mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  input  logic                     boot_cnt_clr,
  output logic [SRAM_ADDR_W-2:0]   boot_wr_cnt,
  output logic                     boot_err
);
  localparam int CW = SRAM_ADDR_W - 1;
  typedef enum logic {IDLE, ACK} state_t;
  state_t         state_q, state_d;
  logic           rd_q, rd_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           boot_ok, boot_oob, cpu_issue;
  logic           unused_addr_lsbs;
  assign unused_addr_lsbs = ^{boot_addr[1:0], cpu_addr[1:0]};
  assign boot_ok   = boot_valid && ((boot_addr >> SRAM_ADDR_W) == '0);
  assign boot_oob  = boot_valid && !boot_ok;
  // any boot_valid, even an out-of-range one, stalls the CPU for that cycle
  assign cpu_issue = (state_q == IDLE) && cpu_valid && !boot_valid;
  always_comb begin
    state_d     = cpu_issue ? ACK : IDLE;
    rd_d        = cpu_issue ? (cpu_wstrb == '0) : rd_q;
    cnt_d       = boot_cnt_clr ? CW'(boot_ok) : (boot_ok && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    err_d       = boot_oob || (err_q && !boot_cnt_clr);
    mem_en      = boot_ok || cpu_issue;
    mem_we      = boot_ok ? boot_wstrb : cpu_issue ? cpu_wstrb : '0;
    mem_addr    = boot_ok ? boot_addr[SRAM_ADDR_W-1:2] : cpu_issue ? cpu_addr[SRAM_ADDR_W-1:2] : '0;
    mem_wdata   = boot_ok ? boot_wdata : cpu_issue ? cpu_wdata : '0;
    cpu_ready   = state_q == ACK;
    cpu_rdata   = (state_q == ACK && rd_q) ? mem_rdata : '0;
    boot_wr_cnt = cnt_q;
    boot_err    = err_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end
endmodule
